// File: rtl/bit_unscramble.sv
// Streaming bit-lane un-permuter: restores out_data[map[j]] = in_data[j] through a
// one-stage valid/ready register, with a serial checker that validates each committed map.
module bit_unscramble #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [IDX_W-1:0] cfg_src,
  input  logic             cfg_commit,
  output logic             cfg_busy,
  output logic             cfg_ok,
  output logic             cfg_err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CHECK = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] map_q [WIDTH];
  logic [IDX_W-1:0] map_d [WIDTH];
  logic [WIDTH-1:0] seen_q, seen_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic             dup_q, dup_d;
  logic             cfg_ok_q, cfg_ok_d;
  logic             cfg_err_q, cfg_err_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic             cfg_wr;
  logic [IDX_W-1:0] cur;
  logic             hit;
  logic             accept;
  logic [WIDTH-1:0] perm;

  // Lane indices are only meaningful below WIDTH (matters when WIDTH is not a power of two).
  function automatic logic in_range(input logic [IDX_W-1:0] v);
    return 32'(v) < WIDTH;
  endfunction

  assign cfg_wr = (state_q == ST_IDLE) && cfg_we && in_range(cfg_idx);
  assign cur    = map_q[k_q];
  assign hit    = in_range(cur) ? seen_q[cur] : 1'b1;

  // Map write port; idle-only so the checker always sees a frozen map.
  always_comb begin
    map_d = map_q;
    if (cfg_wr) map_d[cfg_idx] = cfg_src;
  end

  // Checker FSM: one map entry per cycle, duplicate/out-of-range sticky in dup.
  always_comb begin
    state_d   = state_q;
    seen_d    = seen_q;
    k_d       = k_q;
    dup_d     = dup_q;
    cfg_ok_d  = cfg_ok_q;
    cfg_err_d = cfg_err_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_wr) cfg_ok_d = 1'b0;
        if (cfg_commit) begin
          state_d   = ST_CHECK;
          seen_d    = '0;
          k_d       = '0;
          dup_d     = 1'b0;
          cfg_ok_d  = 1'b0;
          cfg_err_d = 1'b0;
        end
      end
      ST_CHECK: begin
        dup_d = dup_q | hit;
        if (in_range(cur)) seen_d[cur] = 1'b1;
        k_d = k_q + IDX_W'(1);
        if (k_q == IDX_W'(WIDTH - 1)) begin
          state_d   = ST_IDLE;
          k_d       = '0;
          cfg_ok_d  = !(dup_q | hit);
          cfg_err_d = dup_q | hit;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready = cfg_ok_q && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Scatter each scrambled lane back to its original bit position.
  always_comb begin
    perm = '0;
    for (int unsigned j = 0; j < WIDTH; j++) begin
      if (in_range(map_q[j])) perm[map_q[j]] = in_data[j];
    end
  end

  always_comb begin
    out_valid_d = accept || (out_valid_q && !out_ready);
    out_data_d  = accept ? perm : out_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      for (int unsigned j = 0; j < WIDTH; j++) map_q[j] <= IDX_W'(j);
      seen_q      <= '0;
      k_q         <= '0;
      dup_q       <= 1'b0;
      cfg_ok_q    <= 1'b1;
      cfg_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      map_q       <= map_d;
      seen_q      <= seen_d;
      k_q         <= k_d;
      dup_q       <= dup_d;
      cfg_ok_q    <= cfg_ok_d;
      cfg_err_q   <= cfg_err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign cfg_busy  = (state_q == ST_CHECK);
  assign cfg_ok    = cfg_ok_q;
  assign cfg_err   = cfg_err_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
